// File: rtl/conv2_seq_ctrl.sv
// conv2 stage sequencer: paces pixels into conv2_buf, launches conv2_calc per KxK window.
// Optional statistics (win_count, proto_err) are built only when CONV2_SEQ_STAT_EN is defined.
`timescale 1ns/1ps

module conv2_seq_ctrl #(
    parameter int WIDTH  = 15,
    parameter int HEIGHT = 19,
    parameter int K      = 3,
    parameter int IN_DIV = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      buf_shift_en,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      calc_start,
    input  logic                      calc_done,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               win_count,
    output logic                      proto_err
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int PW = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;

    localparam logic [CW-1:0] COL_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_KM1     = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_KM1     = RW'(K - 1);
    localparam logic [PW-1:0] PACE_RELOAD = PW'(IN_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        LAUNCH,
        CALC,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] outCol_q, outCol_d;
    logic [RW-1:0] outRow_q, outRow_d;
    logic [PW-1:0] pace_q, pace_d;
    logic          lastPix_q, lastPix_d;
    logic          isLast;

    assign isLast = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            outCol_q  <= '0;
            outRow_q  <= '0;
            pace_q    <= '0;
            lastPix_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            outCol_q  <= outCol_d;
            outRow_q  <= outRow_d;
            pace_q    <= pace_d;
            lastPix_q <= lastPix_d;
        end
    end

    // Raster position wraps to 0,0 straight after the last pixel; lastPix_q remembers
    // that the frame is exhausted so CALC knows whether to finish or resume.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        outCol_d  = outCol_q;
        outRow_d  = outRow_q;
        lastPix_d = lastPix_q;
        pace_d    = (pace_q != '0) ? pace_q - 1'b1 : pace_q;
        case (state_q)
            IDLE: begin
                pace_d = pace_q;
                if (start) begin
                    col_d     = '0;
                    row_d     = '0;
                    pace_d    = '0;
                    lastPix_d = 1'b0;
                    state_d   = ACCEPT;
                end
            end
            ACCEPT: begin
                if (buf_shift_en) begin
                    pace_d = PACE_RELOAD;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (isLast) begin
                        lastPix_d = 1'b1;
                    end
                    if ((row_q >= ROW_KM1) && (col_q >= COL_KM1)) begin
                        outRow_d = row_q - ROW_KM1;
                        outCol_d = col_q - COL_KM1;
                        state_d  = LAUNCH;
                    end else if (isLast) begin
                        state_d = DONE;
                    end
                end
            end
            LAUNCH: state_d = CALC;
            CALC: begin
                if (calc_done) begin
                    state_d = lastPix_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                lastPix_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        buf_shift_en = 1'b0;
        calc_start   = 1'b0;
        frame_done   = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            ACCEPT: begin
                in_ready     = (pace_q == '0);
                buf_shift_en = (pace_q == '0) && in_valid;
            end
            LAUNCH:  calc_start = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    assign col     = col_q;
    assign row     = row_q;
    assign out_col = outCol_q;
    assign out_row = outRow_q;

`ifdef CONV2_SEQ_STAT_EN
    logic [15:0] winCount_q;
    logic        protoErr_q;

    // proto_err is sticky until reset; win_count restarts with every accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winCount_q <= '0;
            protoErr_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                winCount_q <= '0;
            end else if (state_q == LAUNCH) begin
                winCount_q <= winCount_q + 1'b1;
            end
            if ((calc_done && (state_q != CALC)) || (start && (state_q != IDLE))) begin
                protoErr_q <= 1'b1;
            end
        end
    end

    assign win_count = winCount_q;
    assign proto_err = protoErr_q;
`else
    assign win_count = '0;
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Self-checking bench for conv2_seq_ctrl: randomized pixel gaps and calc latencies
// checked against a raster/window model built from plain arithmetic.
`timescale 1ns/1ps

module tb_conv2_seq_ctrl;

    localparam int WIDTH  = 15;
    localparam int HEIGHT = 19;
    localparam int K      = 3;
    localparam int IN_DIV = 8;
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(HEIGHT);
    localparam int NWIN   = (WIDTH - K + 1) * (HEIGHT - K + 1);
    localparam int NPIX   = WIDTH * HEIGHT;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          buf_shift_en;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          calc_start;
    logic          calc_done;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          busy;
    logic          frame_done;
    logic [15:0]   win_count;
    logic          proto_err;

    int errors = 0;
    int checks = 0;
    bit protoSticky = 1'b0;

    conv2_seq_ctrl #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .K     (K),
        .IN_DIV(IN_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .buf_shift_en(buf_shift_en),
        .col         (col),
        .row         (row),
        .calc_start  (calc_start),
        .calc_done   (calc_done),
        .out_col     (out_col),
        .out_row     (out_row),
        .busy        (busy),
        .frame_done  (frame_done),
        .win_count   (win_count),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkResetOutputs();
        checkBit("rstInReady", in_ready, 1'b0);
        checkBit("rstShiftEn", buf_shift_en, 1'b0);
        checkOutput("rstCol", 32'(col), 0);
        checkOutput("rstRow", 32'(row), 0);
        checkBit("rstCalcStart", calc_start, 1'b0);
        checkOutput("rstOutCol", 32'(out_col), 0);
        checkOutput("rstOutRow", 32'(out_row), 0);
        checkBit("rstBusy", busy, 1'b0);
        checkBit("rstFrameDone", frame_done, 1'b0);
        checkOutput("rstWinCount", 32'(win_count), 0);
        checkBit("rstProtoErr", proto_err, 1'b0);
    endtask

    // calcDelay==0 picks a random calc latency per window; abortAt>0 resets after that many accepts.
    task automatic applyStimulus(input int calcDelay, input bit gaps, input int abortAt, input bit spurious);
        int  expRow[$];
        int  expCol[$];
        int  acceptCount = 0;
        int  lastAcceptCycle = -100;
        int  cycle = 0;
        int  countdown = 0;
        int  doneCycle = -100;
        int  launches = 0;
        int  holes = 0;
        int  snapRow = 0;
        int  snapCol = 0;
        int  r;
        int  c;
        int  expWin;
        bit  inCalc = 1'b0;
        bit  finished = 1'b0;
        for (int rr = 0; rr <= HEIGHT - K; rr++) begin
            for (int cc = 0; cc <= WIDTH - K; cc++) begin
                expRow.push_back(rr);
                expCol.push_back(cc);
            end
        end
        @(negedge clk);
        checkBit("idleBusy", busy, 1'b0);
        start     = 1'b1;
        in_valid  = 1'b0;
        calc_done = 1'b0;
        while (!finished && cycle < 30000) begin
            @(negedge clk);
            cycle++;
            start     = 1'b0;
            calc_done = 1'b0;
            in_valid  = 1'b0;
            checkBit("busy", busy, 1'b1);
            checkBit("frameDone", frame_done, (cycle == doneCycle + 1) && (acceptCount == NPIX));
            if (calc_start) begin
                if (expRow.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL extraLaunch observed=%0d expected=%0d", launches + 1, NWIN);
                end else begin
                    r = expRow.pop_front();
                    c = expCol.pop_front();
                    checkOutput("outRow", 32'(out_row), r);
                    checkOutput("outCol", 32'(out_col), c);
                    checkOutput("launchPixel", acceptCount - 1, (r + K - 1) * WIDTH + c + K - 1);
                    checkOutput("launchLatency", cycle, lastAcceptCycle + 1);
                end
                launches++;
                inCalc    = 1'b1;
                countdown = (calcDelay > 0) ? calcDelay : int'($urandom_range(1, 12));
                snapRow   = int'(row);
                snapCol   = int'(col);
            end else if (inCalc) begin
                checkBit("calcReady", in_ready, 1'b0);
                checkOutput("calcRow", 32'(row), snapRow);
                checkOutput("calcCol", 32'(col), snapCol);
                countdown--;
                if (countdown == 0) begin
                    calc_done = 1'b1;
                    inCalc    = 1'b0;
                    doneCycle = cycle;
                end
            end
            if (cycle == doneCycle + 1) begin
                if (acceptCount == NPIX) begin
                    checkOutput("doneRow", 32'(row), 0);
                    checkOutput("doneCol", 32'(col), 0);
                    checkOutput("launchTotal", launches, NWIN);
`ifdef CONV2_SEQ_STAT_EN
                    expWin = launches;
                    checkBit("protoErr", proto_err, protoSticky);
`else
                    expWin = 0;
                    checkBit("protoErr", proto_err, 1'b0);
`endif
                    checkOutput("winCount", 32'(win_count), expWin);
                    finished = 1'b1;
                end else begin
                    checkBit("resumeReady", in_ready, (cycle - lastAcceptCycle) >= IN_DIV);
                end
            end
            if (!finished) begin
                if (gaps && holes > 0) begin
                    holes--;
                end else begin
                    in_valid = 1'b1;
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        holes = int'($urandom_range(0, 20));
                    end
                end
                if (spurious && in_ready && $urandom_range(0, 7) == 0) begin
                    calc_done   = 1'b1;
                    protoSticky = 1'b1;
                end
                if (spurious && inCalc && $urandom_range(0, 3) == 0) begin
                    start       = 1'b1;
                    protoSticky = 1'b1;
                end
            end
            #1;
            checkBit("shiftEn", buf_shift_en, in_ready && in_valid);
            if (buf_shift_en) begin
                checkOutput("acceptRow", 32'(row), acceptCount / WIDTH);
                checkOutput("acceptCol", 32'(col), acceptCount % WIDTH);
                if (acceptCount > 0) begin
                    checkBit("paceSpacing", (cycle - lastAcceptCycle) >= IN_DIV, 1'b1);
                end
                lastAcceptCycle = cycle;
                acceptCount++;
                if (abortAt > 0 && acceptCount == abortAt) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    #1;
                    checkResetOutputs();
                    in_valid    = 1'b0;
                    calc_done   = 1'b0;
                    start       = 1'b0;
                    protoSticky = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $error("[TB] FAIL frameTimeout observed=%0d expected=%0d", launches, NWIN);
        end
        in_valid  = 1'b0;
        calc_done = 1'b0;
        @(negedge clk);
        checkBit("idleAfterBusy", busy, 1'b0);
        checkBit("idleAfterReady", in_ready, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b1;
        calc_done = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs();
        rst      = 1'b0;
        in_valid = 1'b0;

        applyStimulus(3, 1'b0, 0, 1'b0);
        applyStimulus(1, 1'b0, 0, 1'b0);
        applyStimulus(50, 1'b0, 0, 1'b0);
        applyStimulus(3, 1'b0, 100, 1'b0);
        applyStimulus(3, 1'b0, 0, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b1);
        applyStimulus(0, 1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
